uart_prog_loader: RTL
=====================

Name: uart_prog_loader

Overview:
- Upstream feeder for the 2048x8 simple-dual-port program/data BRAM on the Tang Nano 9K CPU board.
- Takes a byte stream from the UART receiver, parses a framed program image, and drives the BRAM write port (port A: address, data, clock enable).
- Holds the CPU in reset while a load is in progress, then flags done or error.

Parameters:
- DEPTH, 2048, BRAM depth in bytes. Frames with a length greater than DEPTH are rejected.
- ADDR_W, 11, write-address width; must satisfy 2^ADDR_W >= DEPTH.
- HEADER, 8'hA5, start-of-frame byte.
- TIMEOUT_CYC, 2700000, maximum idle cycles between bytes inside a frame (100 ms at 27 MHz).

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst_n  in  1  synchronous active-low reset.
- rx_data  in  8  received byte; valid only when rx_valid=1.
- rx_valid  in  1  one-cycle strobe per received byte; may be asserted on consecutive cycles.
- wr_en  out  1  BRAM port-A clock enable (cea).
- wr_addr  out  ADDR_W  BRAM port-A address (ada).
- wr_data  out  8  BRAM port-A write data (din).
- cpu_hold  out  1  1 = hold the CPU in reset while loading.
- done  out  1  level; last frame loaded with a good checksum.
- err  out  1  level; last frame failed.
- loaded_len  out  12  byte count of the last successfully loaded frame.

Behaviour:
- Reset (rst_n=0 sampled at a clk edge): state=IDLE; every output is 0, loaded_len=0; byte counter, checksum and timeout counter are cleared. A reset mid-frame abandons the frame; writes already issued are not undone.
- Frame format: HEADER, LEN_LO, LEN_HI, LEN payload bytes, SUM. SUM is the 8-bit sum, mod 256, of the payload bytes.
- States: IDLE, LEN_LO, LEN_HI, DATA, SUM, DONE, ERR.
- IDLE / DONE / ERR:
  - rx_valid with rx_data==HEADER: go to LEN_LO; done=0, err=0, cpu_hold=1; clear the counter and checksum.
  - Any other byte: ignored; state and outputs hold.
- LEN_LO: latch the low length byte, then go to LEN_HI.
- LEN_HI: form len={hi,lo}.
  - len==0 or len>DEPTH: go to ERR.
  - Otherwise go to DATA.
- DATA, on each rx_valid:
  - Register wr_en=1, wr_addr=cnt[ADDR_W-1:0], wr_data=rx_data. These outputs are valid on the cycle after the strobe (1-cycle latency).
  - wr_en is a single-cycle pulse per byte; consecutive strobes produce consecutive pulses.
  - cnt increments and the checksum accumulates mod 256.
  - When cnt reaches len-1 on this byte, go to SUM.
  - wr_addr never wraps, because len<=DEPTH.
- SUM, on rx_valid:
  - rx_data==checksum: go to DONE; done=1, loaded_len=len.
  - Otherwise go to ERR.
- DONE and ERR: cpu_hold=0. err=1 in ERR; done is 0 in ERR.
- Timeout:
  - Counter clears on every rx_valid and counts every cycle while in LEN_LO, LEN_HI, DATA or SUM.
  - At TIMEOUT_CYC-1 with no strobe: go to ERR.
  - A strobe arriving on the same cycle as the timeout wins; no timeout is taken.
- wr_en is 0 in every state other than the cycle following a DATA byte.
- A new HEADER byte accepted in DONE or ERR restarts loading at address 0.

Optional Feature:
- Macro: UART_PROG_LOADER_ECHO_EN.
- When defined, adds ports tx_data (out, 8), tx_valid (out, 1) and tx_ready (in, 1).
  - Every byte accepted in LEN_LO..SUM is placed in a 1-entry echo buffer and presented on tx_data/tx_valid the next cycle.
  - tx_valid stays high until tx_ready is sampled high.
  - A new byte arriving while the buffer is still full sets state=ERR; the buffer is then flushed.
  - The HEADER byte is also echoed.
- When undefined: no tx ports and no echo logic.

Test Plan:
- Load a good frame: A5 03 00 11 22 33 66.
  - Expect wr_en pulses: addr 0=11, addr 1=22, addr 2=33.
  - Then done=1, err=0, loaded_len=3, cpu_hold=1->0.
- Bad checksum: A5 02 00 AA 55 00.
  - Expect writes to addr 0 and 1, then err=1, done=0, cpu_hold=0.
- Oversize length: A5 01 08 (len=2049).
  - Expect ERR after LEN_HI, no wr_en pulse; a following A5 01 00 7E 7E loads addr 0=7E with done=1.
- Timeout: A5 02 00 11, then idle for TIMEOUT_CYC cycles (sim value 100).
  - Expect err=1 at cycle 100; one write only (addr 0=11).
- Reset mid-DATA: rst_n=0 after 2 of 4 payload bytes.
  - Expect all outputs 0 the following cycle; the next full frame writes starting at addr 0.
- With UART_PROG_LOADER_ECHO_EN defined and tx_ready held 0:
  - Two bytes (A5 then 01) produce a buffer overrun and err=1.
  - With tx_ready=1, every byte of a frame is echoed in order.

Source files
------------

// File: rtl/uart_prog_loader.sv
// UART program-image loader: parses HEADER/LEN/payload/SUM frames and writes the payload into BRAM port A.
// Optional echo path enabled by defining UART_PROG_LOADER_ECHO_EN.
module uart_prog_loader #(
  parameter int         DEPTH       = 2048,
  parameter int         ADDR_W      = 11,
  parameter logic [7:0] HEADER      = 8'hA5,
  parameter int         TIMEOUT_CYC = 2700000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
`ifdef UART_PROG_LOADER_ECHO_EN
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
`endif
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              cpu_hold,
  output logic              done,
  output logic              err,
  output logic [11:0]       loaded_len
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_SUM, S_DONE, S_ERR
  } state_t;

  state_t          r_state, w_next;
  logic [7:0]      r_lo, r_sum;
  logic [11:0]     r_len, r_cnt;
  logic [TW-1:0]   r_tmo;
  logic [15:0]     w_len;
  logic            w_active, w_hdr, w_tmo, w_ovr;

  assign w_len    = {rx_data, r_lo};
  assign w_active = (r_state == S_LEN_LO) || (r_state == S_LEN_HI) ||
                    (r_state == S_DATA)   || (r_state == S_SUM);
  assign w_hdr    = rx_valid && (rx_data == HEADER) && !w_active;
  // A strobe on the expiry cycle takes priority over the timeout.
  assign w_tmo    = w_active && !rx_valid && (r_tmo == TW'(TIMEOUT_CYC - 1));

`ifdef UART_PROG_LOADER_ECHO_EN
  logic w_echo;
  assign w_echo = rx_valid && (w_active || w_hdr);
  // Buffer frees on the same cycle tx_ready is seen, so back-to-back bytes are fine.
  assign w_ovr  = w_echo && tx_valid && !tx_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_valid <= 1'b0;
      tx_data  <= '0;
    end else if (w_ovr) begin
      tx_valid <= 1'b0;
    end else if (w_echo) begin
      tx_valid <= 1'b1;
      tx_data  <= rx_data;
    end else if (tx_ready) begin
      tx_valid <= 1'b0;
    end
  end
`else
  assign w_ovr = 1'b0;
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_LEN_LO: if (rx_valid) w_next = S_LEN_HI;
      S_LEN_HI: begin
        if (rx_valid) begin
          if (w_len == 16'd0 || w_len > 16'(DEPTH)) w_next = S_ERR;
          else                                      w_next = S_DATA;
        end
      end
      S_DATA:   if (rx_valid && r_cnt == r_len - 12'd1) w_next = S_SUM;
      S_SUM: begin
        if (rx_valid) begin
          if (rx_data == r_sum) w_next = S_DONE;
          else                  w_next = S_ERR;
        end
      end
      default:  if (w_hdr) w_next = S_LEN_LO;
    endcase
    if (w_tmo || w_ovr) w_next = S_ERR;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_lo       <= '0;
      r_sum      <= '0;
      r_len      <= '0;
      r_cnt      <= '0;
      r_tmo      <= '0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      cpu_hold   <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      loaded_len <= '0;
    end else begin
      r_state <= w_next;
      wr_en   <= 1'b0;
      r_tmo   <= (w_active && !rx_valid) ? r_tmo + 1'b1 : '0;
      case (r_state)
        S_LEN_LO: if (rx_valid) r_lo <= rx_data;
        S_LEN_HI: if (rx_valid) r_len <= w_len[11:0];
        S_DATA: begin
          if (rx_valid && !w_ovr) begin
            wr_en   <= 1'b1;
            wr_addr <= r_cnt[ADDR_W-1:0];
            wr_data <= rx_data;
            r_cnt   <= r_cnt + 12'd1;
            r_sum   <= r_sum + rx_data;
          end
        end
        default: ;
      endcase
      if (w_next == S_LEN_LO && !w_active) begin
        done     <= 1'b0;
        err      <= 1'b0;
        cpu_hold <= 1'b1;
        r_cnt    <= '0;
        r_sum    <= '0;
      end
      if (w_next == S_DONE && r_state == S_SUM) begin
        done       <= 1'b1;
        cpu_hold   <= 1'b0;
        loaded_len <= r_len;
      end
      if (w_next == S_ERR) begin
        err      <= 1'b1;
        done     <= 1'b0;
        cpu_hold <= 1'b0;
      end
    end
  end

endmodule
